// File: rtl/seq_alu.sv
// seq_alu: multi-cycle signed ALU for WIDTH-bit operands with a start/done
// handshake. It computes add, sub, mul (full 2*WIDTH product) and div
// (quotient in the upper half, remainder in the lower half).
//
// Ports:
//   clock    - rising-edge clock
//   reset_n  - asynchronous active-low reset
//   start    - request a new operation, sampled only while idle
//   a, b     - signed operands (a is the dividend, b is the divisor)
//   func     - 00 add, 01 sub, 10 mul, 11 div
//   busy     - high while an accepted operation is in progress
//   done     - one-cycle pulse when out/overflow are updated
//   out      - result, held until the next done
//   overflow - result does not fit its field, held with out
module seq_alu #(
   parameter int WIDTH = 6
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [1:0]         func,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] out,
   output logic               overflow
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   state_t state;
   state_t nextState;

   logic [WIDTH-1:0]   aLat;
   logic [WIDTH-1:0]   bLat;
   logic [1:0]         funcLat;
   logic [CW-1:0]      count;

   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;

   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   dvsr;

   logic [WIDTH-1:0]   aMag;
   logic [WIDTH-1:0]   bMag;
   logic [WIDTH:0]     remShift;
   logic               quotBit;
   logic [WIDTH-1:0]   remNext;

   logic [WIDTH-1:0]   sum;
   logic [WIDTH-1:0]   diff;
   logic               signsDiffer;
   logic [WIDTH-1:0]   quotSigned;
   logic [WIDTH-1:0]   remSigned;
   logic [2*WIDTH-1:0] result;
   logic               resultOvf;

   assign busy = (state != IDLE);

   // Magnitudes of the live operands, taken as unsigned WIDTH-bit values so
   // that the most negative operand maps cleanly onto 2^(WIDTH-1).
   always_comb begin
      aMag = a[WIDTH-1] ? -a : a;
      bMag = b[WIDTH-1] ? -b : b;
   end

   // One restoring-division step: the quotient register doubles as the
   // dividend shifter, so its MSB feeds the partial remainder while the new
   // quotient bit enters at the bottom.
   always_comb begin
      remShift = {rem, quot[WIDTH-1]};
      quotBit  = (remShift >= {1'b0, dvsr});
      remNext  = quotBit ? WIDTH'(remShift - {1'b0, dvsr}) : remShift[WIDTH-1:0];
   end

   // Final result formatting from the latched operands and the magnitude
   // datapath. A positive quotient with its MSB set can only be +2^(WIDTH-1)
   // (most negative divided by -1), which is the one quotient overflow case.
   always_comb begin
      sum         = aLat + bLat;
      diff        = aLat - bLat;
      signsDiffer = aLat[WIDTH-1] ^ bLat[WIDTH-1];
      quotSigned  = signsDiffer ? -quot : quot;
      remSigned   = aLat[WIDTH-1] ? -rem : rem;
      result      = '0;
      resultOvf   = 1'b0;
      unique case (funcLat)
         2'b00: begin
            result    = {{WIDTH{sum[WIDTH-1]}}, sum};
            resultOvf = (aLat[WIDTH-1] == bLat[WIDTH-1]) && (sum[WIDTH-1] != aLat[WIDTH-1]);
         end
         2'b01: begin
            result    = {{WIDTH{diff[WIDTH-1]}}, diff};
            resultOvf = (aLat[WIDTH-1] != bLat[WIDTH-1]) && (diff[WIDTH-1] != aLat[WIDTH-1]);
         end
         2'b10: begin
            result    = signsDiffer ? -prod : prod;
            resultOvf = 1'b0;
         end
         default: begin
            if (bLat == '0) begin
               result    = {{WIDTH{1'b1}}, aLat};
               resultOvf = 1'b1;
            end else begin
               result    = {quotSigned, remSigned};
               resultOvf = !signsDiffer && quot[WIDTH-1];
            end
         end
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic: add/sub skip straight to the formatting cycle, while
   // mul/div spend WIDTH cycles iterating first.
   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               nextState = func[1] ? CALC : FIX;
            end
         end
         CALC: begin
            if (count == LAST) begin
               nextState = FIX;
            end
         end
         FIX: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Datapath: latch operands on accept, iterate multiply and divide in
   // parallel during CALC (only the one selected by funcLat is used), and
   // register the formatted result on the FIX edge. done is a pure
   // registered copy of "we were in FIX", so it lasts exactly one cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         aLat     <= '0;
         bLat     <= '0;
         funcLat  <= '0;
         count    <= '0;
         prod     <= '0;
         mcand    <= '0;
         mplier   <= '0;
         quot     <= '0;
         rem      <= '0;
         dvsr     <= '0;
         out      <= '0;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= (state == FIX);
         unique case (state)
            IDLE: begin
               if (start) begin
                  aLat    <= a;
                  bLat    <= b;
                  funcLat <= func;
                  count   <= '0;
                  prod    <= '0;
                  mcand   <= {{WIDTH{1'b0}}, aMag};
                  mplier  <= bMag;
                  quot    <= aMag;
                  rem     <= '0;
                  dvsr    <= bMag;
               end
            end
            CALC: begin
               if (mplier[0]) begin
                  prod <= prod + mcand;
               end
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               quot   <= {quot[WIDTH-2:0], quotBit};
               rem    <= remNext;
               count  <= count + 1'b1;
            end
            FIX: begin
               out      <= result;
               overflow <= resultOvf;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: self-checking bench for seq_alu. Directed cases from the
// intended behaviour plus random operand/func vectors, all compared with an
// integer-arithmetic reference model. Operations are issued back to back,
// each new start raised in the previous operation's done cycle.
module tb_seq_alu;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic [5:0]  a;
   logic [5:0]  b;
   logic [1:0]  func;
   logic        busy;
   logic        done;
   logic [11:0] out;
   logic        overflow;

   int          checks;
   int          errors;
   logic [11:0] lastOut;
   logic        lastOvf;

   seq_alu #(.WIDTH(6)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .func     (func),
      .busy     (busy),
      .done     (done),
      .out      (out),
      .overflow (overflow)
   );

   // Free-running clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Watchdog so a stuck design can never hang the run.
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model from plain integer arithmetic: returns {overflow, out}.
   function automatic logic [12:0] model(input int x, input int y, input logic [1:0] f);
      int          r;
      int          q;
      int          w;
      logic        ov;
      logic [11:0] o;
      logic [5:0]  qf;
      logic [5:0]  rf;
      ov = 1'b0;
      o  = '0;
      case (f)
         2'b00: begin
            r  = x + y;
            ov = (r > 31) || (r < -32);
            w  = (r + 96) % 64 - 32;
            o  = 12'(w);
         end
         2'b01: begin
            r  = x - y;
            ov = (r > 31) || (r < -32);
            w  = (r + 96) % 64 - 32;
            o  = 12'(w);
         end
         2'b10: begin
            o  = 12'(x * y);
            ov = 1'b0;
         end
         default: begin
            if (y == 0) begin
               ov = 1'b1;
               rf = 6'(x);
               o  = {6'h3F, rf};
            end else begin
               q  = x / y;
               r  = x % y;
               ov = (q > 31);
               qf = 6'(q);
               rf = 6'(r);
               o  = {qf, rf};
            end
         end
      endcase
      return {ov, o};
   endfunction

   // Single comparison point: counts the check and reports any difference.
   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Issue one operation and follow it to done. Called either from idle or
   // from the previous done cycle, so start lands just after an active edge.
   // After accept the operand inputs are scrambled to prove they were
   // latched; with hold set, start also stays high for the whole operation.
   // Returns in the done cycle (1 time unit after its edge).
   task automatic applyStimulus(input int x, input int y, input logic [1:0] f, input bit hold, input string tag);
      logic [12:0] exp;
      int          lat;
      int          wantLat;
      bit          seen;
      exp     = model(x, y, f);
      wantLat = f[1] ? 7 : 1;
      a       = 6'(x);
      b       = 6'(y);
      func    = f;
      start   = 1'b1;
      @(posedge clock);
      #1;
      checkOutput({tag, " busy after accept"}, {15'b0, busy}, 16'h0001);
      start = hold;
      a     = 6'($urandom);
      b     = 6'($urandom);
      func  = 2'($urandom);
      lat   = 0;
      seen  = 1'b0;
      while (!seen && lat < 20) begin
         @(posedge clock);
         #1;
         lat++;
         a    = 6'($urandom);
         b    = 6'($urandom);
         func = 2'($urandom);
         if (done) begin
            seen = 1'b1;
         end else begin
            checkOutput({tag, " out held"}, {4'b0, out}, {4'b0, lastOut});
            checkOutput({tag, " overflow held"}, {15'b0, overflow}, {15'b0, lastOvf});
         end
      end
      checkOutput({tag, " latency"}, 16'(lat), 16'(wantLat));
      checkOutput({tag, " out"}, {4'b0, out}, {4'b0, exp[11:0]});
      checkOutput({tag, " overflow"}, {15'b0, overflow}, {15'b0, exp[12]});
      checkOutput({tag, " busy at done"}, {15'b0, busy}, 16'h0000);
      lastOut = exp[11:0];
      lastOvf = exp[12];
      if (hold) begin
         start = 1'b0;
         @(posedge clock);
         #1;
         checkOutput({tag, " single done"}, {15'b0, done}, 16'h0000);
         checkOutput({tag, " idle after hold"}, {15'b0, busy}, 16'h0000);
      end
   endtask

   // Main sequence: reset, directed cases, handshake, mid-op reset, random.
   initial begin
      int          dones;
      int          x;
      int          y;
      logic [1:0]  f;
      checks  = 0;
      errors  = 0;
      lastOut = '0;
      lastOvf = 1'b0;
      start   = 1'b0;
      a       = '0;
      b       = '0;
      func    = '0;
      reset_n = 1'b0;
      #12;
      checkOutput("reset busy", {15'b0, busy}, 16'h0000);
      checkOutput("reset done", {15'b0, done}, 16'h0000);
      checkOutput("reset out", {4'b0, out}, 16'h0000);
      checkOutput("reset overflow", {15'b0, overflow}, 16'h0000);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      applyStimulus(31, 1, 2'b00, 1'b0, "add ovf");
      applyStimulus(-3, 5, 2'b00, 1'b0, "add");
      applyStimulus(-32, 1, 2'b01, 1'b0, "sub ovf");
      applyStimulus(5, 7, 2'b01, 1'b0, "sub");
      applyStimulus(-32, -32, 2'b10, 1'b0, "mul max");
      applyStimulus(-7, 9, 2'b10, 1'b0, "mul neg");
      applyStimulus(31, 5, 2'b11, 1'b0, "div");
      applyStimulus(-7, 2, 2'b11, 1'b0, "div neg");
      applyStimulus(-32, -1, 2'b11, 1'b0, "div ovf");
      applyStimulus(-32, 1, 2'b11, 1'b0, "div min");
      applyStimulus(-13, 0, 2'b11, 1'b0, "div zero");
      applyStimulus(17, 0, 2'b11, 1'b0, "div zero pos");
      applyStimulus(-25, 11, 2'b10, 1'b1, "mul held start");
      applyStimulus(23, -4, 2'b11, 1'b0, "div b2b");

      a       = 6'(-29);
      b       = 6'(3);
      func    = 2'b11;
      start   = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      checkOutput("abort busy", {15'b0, busy}, 16'h0000);
      checkOutput("abort done", {15'b0, done}, 16'h0000);
      checkOutput("abort out", {4'b0, out}, 16'h0000);
      checkOutput("abort overflow", {15'b0, overflow}, 16'h0000);
      lastOut = '0;
      lastOvf = 1'b0;
      #10;
      reset_n = 1'b1;
      dones   = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock);
         #1;
         if (done) dones++;
      end
      checkOutput("abort no done", 16'(dones), 16'h0000);
      applyStimulus(-29, 3, 2'b11, 1'b0, "after abort");

      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            x = ($urandom_range(0, 1) == 1) ? 31 : -32;
         end else begin
            x = int'($urandom_range(0, 63)) - 32;
         end
         case ($urandom_range(0, 7))
            0:       y = 0;
            1:       y = -1;
            2:       y = -32;
            default: y = int'($urandom_range(0, 63)) - 32;
         endcase
         f = 2'($urandom_range(0, 3));
         applyStimulus(x, y, f, 1'b0, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
